// File: rtl/eth_adapt_pkg.sv
// Shared types and constants for the Ethernet adaptation block:
// completer FSM states, pserr encodings and the sequencer command codes.
package eth_adapt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AV_REQ = 3'd1,
    ST_RESP   = 3'd2,
    ST_DRAIN  = 3'd3
  } cmp_state_e;

  localparam logic PSERR_NONE = 1'b0;
  localparam logic PSERR_SET  = 1'b1;

  typedef enum logic [1:0] {
    CMD_NOP = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2
  } cmd_e;

endpackage

// File: rtl/eth_adapt_apb_completer.sv
// APB completer bridging each transfer to an 8-bit Avalon-MM reconfig port,
// with address-window decode, waitrequest timeout and pserr reporting.
module eth_adapt_apb_completer
  import eth_adapt_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic [31:0]       paddr,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pserr,
  output logic [ADDR_W-1:0] avmm_address,
  output logic              avmm_read,
  output logic              avmm_write,
  output logic [7:0]        avmm_writedata,
  input  logic [7:0]        avmm_readdata,
  input  logic              avmm_waitrequest,
  output logic [15:0]       stat_timeout_cnt,
  output logic [2:0]        stat_state
);

  localparam int WIN_LSB = ADDR_W + 2;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);

  cmp_state_e        r_state;
  cmp_state_e        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  cmd_e              r_cmd;
  logic [31:0]       r_prdata;
  logic              r_pserr;
  logic [TW-1:0]     r_tcnt;
  logic [15:0]       r_timeout_cnt;

  logic w_req;
  logic w_aligned;
  logic w_in_window;
  logic w_timeout;
  logic w_start;
  logic w_done;
  logic w_expire;
  logic w_decode_err;
  logic w_unused_pwdata;

  assign w_req           = psel & penable;
  assign w_aligned       = (paddr[1:0] == 2'b00);
  // BASE_ADDR is window-aligned, so a range check reduces to matching the upper bits.
  assign w_in_window     = (paddr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign w_timeout       = (r_tcnt == TW'(TIMEOUT_CYC - 1));
  assign w_unused_pwdata = ^pwdata[31:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_start        = 1'b0;
    w_done         = 1'b0;
    w_expire       = 1'b0;
    w_decode_err   = 1'b0;
    pready         = 1'b0;
    prdata         = 32'h0;
    pserr          = 1'b0;
    avmm_read      = 1'b0;
    avmm_write     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (!w_aligned || !w_in_window) begin
            w_decode_err = 1'b1;
            w_state_next = ST_RESP;
          end else begin
            w_start      = 1'b1;
            w_state_next = ST_AV_REQ;
          end
        end
      end
      ST_AV_REQ: begin
        avmm_read  = (r_cmd == CMD_RD);
        avmm_write = (r_cmd == CMD_WR);
        if (!avmm_waitrequest) begin
          w_done       = 1'b1;
          w_state_next = ST_RESP;
        end else if (w_timeout) begin
          w_expire     = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // An initiator that dropped psel gets no pready and no drain phase.
        pready       = psel;
        prdata       = psel ? r_prdata : 32'h0;
        pserr        = psel & r_pserr;
        w_state_next = psel ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (!psel) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_wdata       <= 8'h0;
      r_cmd         <= CMD_NOP;
      r_prdata      <= 32'h0;
      r_pserr       <= PSERR_NONE;
      r_tcnt        <= '0;
      r_timeout_cnt <= 16'h0;
    end else begin
      if (w_start) begin
        r_addr  <= paddr[WIN_LSB-1:2];
        r_wdata <= pwdata[7:0];
        r_cmd   <= pwrite ? CMD_WR : CMD_RD;
        r_tcnt  <= '0;
      end else if (r_state == ST_AV_REQ && avmm_waitrequest && !w_timeout) begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      if (w_decode_err) begin
        r_prdata <= 32'h0;
        r_pserr  <= PSERR_SET;
      end else if (w_done) begin
        r_prdata <= (r_cmd == CMD_RD) ? {24'h0, avmm_readdata} : 32'h0;
        r_pserr  <= PSERR_NONE;
      end else if (w_expire) begin
        r_prdata <= 32'h0;
        r_pserr  <= PSERR_SET;
        if (r_timeout_cnt != 16'hFFFF) begin
          r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
      end
    end
  end

  assign avmm_address     = r_addr;
  assign avmm_writedata   = r_wdata;
  assign stat_timeout_cnt = r_timeout_cnt;
  assign stat_state       = r_state;

endmodule

// File: doc/eth_adapt_apb_completer.md
Name: eth_adapt_apb_completer

Overview:
- APB completer that terminates the adaptation sequencer's APB initiator port.
- Bridges each APB transfer to an 8-bit Avalon-MM transceiver reconfiguration port that uses waitrequest.
- Decodes the address window, enforces a waitrequest timeout and reports errors on pserr.
- Sits between the sequencer and the XCVR reconfig interface inside the Ethernet wrapper.

Parameters:
- ADDR_W, 10, Avalon word-address width; the window spans 4*2^ADDR_W bytes.
- BASE_ADDR, 32'h0000_0000, byte base of the window; must be aligned to 4*2^ADDR_W.
- TIMEOUT_CYC, 1024, maximum cycles an Avalon command is held before abort; must be >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable; may rise in the same cycle as psel.
- paddr  in  32  APB byte address.
- pwrite  in  1  1 = write.
- pwdata  in  32  write data; only [7:0] is used.
- pready  out  1  one-cycle transfer-complete pulse.
- prdata  out  32  {24'b0, read byte}; valid only while pready=1.
- pserr  out  1  error flag; valid only while pready=1.
- avmm_address  out  ADDR_W  word address, equal to paddr[ADDR_W+1:2].
- avmm_read  out  1  Avalon read.
- avmm_write  out  1  Avalon write.
- avmm_writedata  out  8  write data, equal to pwdata[7:0].
- avmm_readdata  in  8  read data; valid in the cycle waitrequest=0.
- avmm_waitrequest  in  1  stall.
- stat_timeout_cnt  out  16  saturating count of timed-out accesses.
- stat_state  out  3  current FSM state encoding.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - All outputs are 0 and the state is IDLE.
  - Any in-flight avmm_read/avmm_write drops immediately; the aborted access is not replayed after reset.
- FSM states: IDLE, AV_REQ, RESP, DRAIN.
- IDLE:
  - Waits for psel & penable.
  - If paddr[1:0]!=0, or paddr is outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_W): go to RESP with pserr=1. No Avalon access is issued.
  - Otherwise, register avmm_address, avmm_writedata and the direction, and assert avmm_read or avmm_write on the next cycle (state AV_REQ).
- AV_REQ:
  - The command is held stable while waitrequest=1; the timeout counter increments each cycle.
  - First cycle with waitrequest=0:
    - Drop the command.
    - For a read, capture prdata={24'b0, avmm_readdata}; for a write, prdata=0.
    - pserr=0; go to RESP.
  - If the command has been held TIMEOUT_CYC cycles and waitrequest is still 1:
    - Drop the command.
    - prdata=0, pserr=1.
    - stat_timeout_cnt increments, saturating at 16'hFFFF.
    - Go to RESP.
- RESP:
  - pready=1 for exactly one cycle, with prdata/pserr valid.
  - Next state is DRAIN.
  - If psel was 0 at entry (initiator abandoned the transfer), pready stays 0 and the next state is IDLE.
- DRAIN:
  - pready, prdata and pserr return to 0.
  - Stay until psel=0, then go to IDLE.
  - This guarantees one Avalon access per APB transfer even if the initiator holds psel.
- Latency, with N = the cycle in which IDLE sees psel&penable:
  - Decode error: pready at N+1.
  - Valid access: command asserted from N+1; if the first waitrequest=0 is in cycle M, pready is at M+1. Minimum pready cycle is N+2.
  - Timeout: the command is asserted for exactly TIMEOUT_CYC cycles; pready at N+1+TIMEOUT_CYC with pserr=1.
- The timeout counter clears on every entry to AV_REQ.
- pwdata[31:8] is ignored.
- Non-IDLE states ignore psel/penable, except for the DRAIN exit condition and the RESP abandon check.

Decomposition:
- eth_adapt_pkg holds:
  - the completer state enum (3 bits);
  - the constants PSERR_NONE/PSERR_SET;
  - the shared CMD_* encodings already used by the sequencer.
- No sub-module: the timeout counter and address decode are small enough to stay inline.

Test Plan:
- Write: paddr=32'h0000_0010, pwdata=32'hA5, waitrequest low immediately -> avmm_write=1 for 1 cycle with address 4 and writedata 8'hA5; pready at N+2; pserr=0.
- Read with stall: paddr=32'h8, waitrequest high 5 cycles, readdata=8'h3C -> avmm_read held 6 cycles; pready one cycle later with prdata=32'h0000_003C and pserr=0.
- Decode error: paddr=32'h0000_1000 (ADDR_W=10) or paddr=32'h2 -> no avmm_read/avmm_write; pready at N+1 with pserr=1 and prdata=0.
- Timeout: waitrequest stuck at 1 with TIMEOUT_CYC=1024 -> command dropped after 1024 cycles; pready with pserr=1; stat_timeout_cnt=1.
- psel held after pready -> exactly one Avalon access; the next access is issued only after psel falls and rises again.
- rst_n asserted during AV_REQ stall -> avmm_read drops in the same cycle and all outputs are 0; after release, a fresh read completes normally.
